reg_file_32: RTL and testbench
==============================

Name: reg_file_32

Overview:
- 32-entry by 32-bit architectural register file for the pipelined CPU.
- One synchronous write port and two read ports; register 0 is hardwired to zero.
- Each storage bit is an enabled D flip-flop.
- A 5-to-32 write decoder gates the per-register enables.
- Sits downstream of the writeback stage; consumed by decode/operand fetch.

Parameters:
- WIDTH, 32, data width of each register and of all data ports.
- DEPTH_LOG2, 5, register address width; register count = 2**DEPTH_LOG2.
- WRITE_BYPASS, 1, when 1, same-cycle write data is forwarded to a matching read port; when 0, reads return stored contents only.

Ports:
- clk  input  1  rising-edge clock.
- ctrl_reset  input  1  asynchronous active-high reset; clears all registers.
- ctrl_writeEnable  input  1  write strobe, sampled at rising clk.
- ctrl_writeReg  input  DEPTH_LOG2  write address.
- data_writeReg  input  WIDTH  write data.
- ctrl_readRegA  input  DEPTH_LOG2  read address, port A.
- ctrl_readRegB  input  DEPTH_LOG2  read address, port B.
- data_readRegA  output  WIDTH  read data, port A.
- data_readRegB  output  WIDTH  read data, port B.

Behaviour:
- **Reset:**
  - ctrl_reset=1 asynchronously forces every register to 0, independent of clk.
  - Both read outputs then read 0 for any address.
  - Reset dominates a simultaneous write: no write lands on an edge where ctrl_reset=1.
  - Deasserting reset between edges leaves registers at 0 until the next qualified write.
- **Write:**
  - On rising clk with ctrl_reset=0, ctrl_writeEnable=1 and ctrl_writeReg!=0, register[ctrl_writeReg] <= data_writeReg.
  - All other registers hold their value (enable low, not re-written).
- **Register 0:**
  - Never written; always reads 0.
  - A write to address 0 is silently dropped and has no side effects.
- **Read:**
  - Both ports are combinational from address to data, with zero latency.
  - A value written at edge N is visible on the read ports immediately after edge N.
  - The two ports are fully independent; A and B may select the same register.
- **Bypass (WRITE_BYPASS=1):**
  - Condition: ctrl_writeEnable=1, ctrl_reset=0, ctrl_writeReg!=0, and ctrl_writeReg equals a port's read address.
  - When the condition holds, that port outputs data_writeReg combinationally, before the edge.
  - Otherwise the port outputs the stored value.
- **Bypass disabled (WRITE_BYPASS=0):**
  - Ports show the old stored value until the edge.
- **Address decode:**
  - One-hot write decode: exactly one register is enabled per qualified write, none otherwise.
  - Read muxes decode the full address; no address aliasing.
- **X handling:**
  - ctrl_writeEnable=0 with X on the address or data must not corrupt any register.

Test Plan:
- Reset: write 0xDEADBEEF to r5, then assert ctrl_reset mid-cycle -> data_readRegA(r5) = 0 immediately, before the next clk edge.
- Basic write/read: write 0x12345678 to r7, then 0xCAFEF00D to r31; read A=r7, B=r31 -> 0x12345678 and 0xCAFEF00D; r1..r6 still 0.
- Zero register: write 0xFFFFFFFF to r0 with enable=1 -> both ports read r0 = 0; no other register changed.
- Write disable: r3=0xAAAA5555, then present data 0x0 with ctrl_writeEnable=0 for 3 edges -> r3 stays 0xAAAA5555.
- Bypass: WRITE_BYPASS=1, r9=0x11111111; drive write r9=0x22222222 with A=r9, B=r10 -> A=0x22222222 before the edge, B=0. Repeat with WRITE_BYPASS=0 -> A=0x11111111 until the edge, then 0x22222222.
- Simultaneous reset and write: ctrl_reset=1 with ctrl_writeEnable=1 writing 0x5A5A5A5A to r12 across an edge -> r12 reads 0 after reset is released, and no bypass is shown during reset.

Source files
------------

// File: rtl/reg_file_32.sv
// 32 x 32 architectural register file: one synchronous write port,
// two combinational read ports, register 0 hardwired to zero.
//
// Ports:
//   clk              rising-edge clock
//   ctrl_reset       asynchronous active-high reset, clears all registers
//   ctrl_writeEnable write strobe, sampled at rising clk
//   ctrl_writeReg    write address
//   data_writeReg    write data
//   ctrl_readRegA    read address, port A
//   ctrl_readRegB    read address, port B
//   data_readRegA    read data, port A
//   data_readRegB    read data, port B
module reg_file_32 #(
    parameter int WIDTH        = 32,
    parameter int DEPTH_LOG2   = 5,
    parameter bit WRITE_BYPASS = 1'b1
) (
    input  logic                  clk,
    input  logic                  ctrl_reset,
    input  logic                  ctrl_writeEnable,
    input  logic [DEPTH_LOG2-1:0] ctrl_writeReg,
    input  logic [WIDTH-1:0]      data_writeReg,
    input  logic [DEPTH_LOG2-1:0] ctrl_readRegA,
    input  logic [DEPTH_LOG2-1:0] ctrl_readRegB,
    output logic [WIDTH-1:0]      data_readRegA,
    output logic [WIDTH-1:0]      data_readRegB
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;

    logic [WIDTH-1:0] regs_q [DEPTH];
    logic [DEPTH-1:1] wr_en;
    logic             wr_qual;
    logic             byp_a;
    logic             byp_b;

    // A write counts only when enabled and not aimed at register 0.
    assign wr_qual = ctrl_writeEnable && (ctrl_writeReg != '0);

    // One-hot write decode; index 0 has no enable so r0 can never load.
    always_comb begin
        wr_en = '0;
        for (int i = 1; i < DEPTH; i++) begin
            wr_en[i] = wr_qual && (ctrl_writeReg == DEPTH_LOG2'(i));
        end
    end

    // Reset has priority over any write on the same edge.
    // Entry 0 is only ever cleared, so it stays a constant zero.
    always_ff @(posedge clk or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 1; i < DEPTH; i++) begin
                if (wr_en[i]) begin
                    regs_q[i] <= data_writeReg;
                end
            end
        end
    end

    // Forward the in-flight write so decode sees it in the same cycle.
    // Gated by reset so nothing leaks through while registers are held clear.
    assign byp_a = WRITE_BYPASS && !ctrl_reset && wr_qual
                   && (ctrl_writeReg == ctrl_readRegA);
    assign byp_b = WRITE_BYPASS && !ctrl_reset && wr_qual
                   && (ctrl_writeReg == ctrl_readRegB);

    assign data_readRegA = byp_a ? data_writeReg : regs_q[ctrl_readRegA];
    assign data_readRegB = byp_b ? data_writeReg : regs_q[ctrl_readRegB];

endmodule

// File: tb/tb_reg_file_32.sv
// Directed self-checking bench for reg_file_32.
// Runs a bypass and a non-bypass instance side by side on shared inputs.
module tb_reg_file_32;

    logic        clk;
    logic        ctrl_reset;
    logic        ctrl_writeEnable;
    logic [4:0]  ctrl_writeReg;
    logic [31:0] data_writeReg;
    logic [4:0]  ctrl_readRegA;
    logic [4:0]  ctrl_readRegB;
    logic [31:0] byp_a;
    logic [31:0] byp_b;
    logic [31:0] nob_a;
    logic [31:0] nob_b;

    int total;
    int bad;

    reg_file_32 #(.WIDTH(32), .DEPTH_LOG2(5), .WRITE_BYPASS(1'b1)) u_byp (
        .clk              (clk),
        .ctrl_reset       (ctrl_reset),
        .ctrl_writeEnable (ctrl_writeEnable),
        .ctrl_writeReg    (ctrl_writeReg),
        .data_writeReg    (data_writeReg),
        .ctrl_readRegA    (ctrl_readRegA),
        .ctrl_readRegB    (ctrl_readRegB),
        .data_readRegA    (byp_a),
        .data_readRegB    (byp_b)
    );

    reg_file_32 #(.WIDTH(32), .DEPTH_LOG2(5), .WRITE_BYPASS(1'b0)) u_nob (
        .clk              (clk),
        .ctrl_reset       (ctrl_reset),
        .ctrl_writeEnable (ctrl_writeEnable),
        .ctrl_writeReg    (ctrl_writeReg),
        .data_writeReg    (data_writeReg),
        .ctrl_readRegA    (ctrl_readRegA),
        .ctrl_readRegB    (ctrl_readRegB),
        .data_readRegA    (nob_a),
        .data_readRegB    (nob_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %08h want %08h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        ctrl_writeEnable = 1'b1;
        ctrl_writeReg    = a;
        data_writeReg    = d;
        @(posedge clk);
        #1;
        ctrl_writeEnable = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a, input logic [4:0] b);
        ctrl_readRegA = a;
        ctrl_readRegB = b;
        #1;
    endtask

    initial begin
        total            = 0;
        bad              = 0;
        ctrl_reset       = 1'b1;
        ctrl_writeEnable = 1'b0;
        ctrl_writeReg    = '0;
        data_writeReg    = '0;
        ctrl_readRegA    = 5'd5;
        ctrl_readRegB    = 5'd31;
        #12;
        chk("rst_a", byp_a, 32'h0);
        chk("rst_b", byp_b, 32'h0);
        @(negedge clk);
        ctrl_reset = 1'b0;

        // Asynchronous reset mid-cycle
        wr(5'd5, 32'hDEADBEEF);
        rd(5'd5, 5'd5);
        chk("r5_wr", byp_a, 32'hDEADBEEF);
        chk("r5_nob", nob_b, 32'hDEADBEEF);
        ctrl_reset = 1'b1;
        #1;
        chk("async_rst_a", byp_a, 32'h0);
        chk("async_rst_nob", nob_a, 32'h0);
        @(negedge clk);
        ctrl_reset = 1'b0;
        #1;
        chk("post_rst_r5", byp_a, 32'h0);

        // Basic write/read
        wr(5'd7, 32'h12345678);
        wr(5'd31, 32'hCAFEF00D);
        rd(5'd7, 5'd31);
        chk("r7_a", byp_a, 32'h12345678);
        chk("r31_b", byp_b, 32'hCAFEF00D);
        chk("r7_nob", nob_a, 32'h12345678);
        rd(5'd31, 5'd31);
        chk("same_a", byp_a, 32'hCAFEF00D);
        chk("same_b", byp_b, 32'hCAFEF00D);
        for (int i = 1; i <= 6; i++) begin
            rd(5'(i), 5'(i + 24));
            chk("low_zero", byp_a, 32'h0);
            chk("hi_zero", nob_b, 32'h0);
        end

        // Zero register write is dropped, no bypass either
        rd(5'd0, 5'd0);
        @(negedge clk);
        ctrl_writeEnable = 1'b1;
        ctrl_writeReg    = 5'd0;
        data_writeReg    = 32'hFFFFFFFF;
        #1;
        chk("r0_nobyp_a", byp_a, 32'h0);
        chk("r0_nobyp_b", byp_b, 32'h0);
        @(posedge clk);
        #1;
        ctrl_writeEnable = 1'b0;
        chk("r0_a", byp_a, 32'h0);
        chk("r0_b", nob_b, 32'h0);
        rd(5'd7, 5'd31);
        chk("r0_side_r7", byp_a, 32'h12345678);
        chk("r0_side_r31", byp_b, 32'hCAFEF00D);
        rd(5'd1, 5'd0);
        chk("r0_side_r1", byp_a, 32'h0);

        // Write disable holds
        wr(5'd3, 32'hAAAA5555);
        @(negedge clk);
        ctrl_writeEnable = 1'b0;
        ctrl_writeReg    = 5'd3;
        data_writeReg    = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        rd(5'd3, 5'd3);
        chk("wdis_a", byp_a, 32'hAAAA5555);
        chk("wdis_nob", nob_b, 32'hAAAA5555);

        // Bypass vs no bypass
        wr(5'd9, 32'h11111111);
        @(negedge clk);
        rd(5'd9, 5'd10);
        ctrl_writeEnable = 1'b1;
        ctrl_writeReg    = 5'd9;
        data_writeReg    = 32'h22222222;
        #1;
        chk("byp_a", byp_a, 32'h22222222);
        chk("byp_b", byp_b, 32'h0);
        chk("nob_a_old", nob_a, 32'h11111111);
        chk("nob_b", nob_b, 32'h0);
        @(posedge clk);
        #1;
        ctrl_writeEnable = 1'b0;
        chk("byp_a_post", byp_a, 32'h22222222);
        chk("nob_a_post", nob_a, 32'h22222222);

        // Reset with simultaneous write
        @(negedge clk);
        rd(5'd12, 5'd7);
        ctrl_reset       = 1'b1;
        ctrl_writeEnable = 1'b1;
        ctrl_writeReg    = 5'd12;
        data_writeReg    = 32'h5A5A5A5A;
        #1;
        chk("rstwr_nobyp", byp_a, 32'h0);
        chk("rstwr_r7", byp_b, 32'h0);
        @(posedge clk);
        #1;
        chk("rstwr_edge", byp_a, 32'h0);
        @(negedge clk);
        ctrl_writeEnable = 1'b0;
        ctrl_reset       = 1'b0;
        #1;
        chk("rstwr_r12", byp_a, 32'h0);
        chk("rstwr_r12_nob", nob_a, 32'h0);
        rd(5'd9, 5'd3);
        chk("rst_r9", byp_a, 32'h0);
        chk("rst_r3", nob_b, 32'h0);

        // Fresh write after reset, distinct pattern per port
        wr(5'd12, 32'h5A5A5A5A);
        wr(5'd20, 32'h0F0F0F0F);
        rd(5'd12, 5'd20);
        chk("r12_after", byp_a, 32'h5A5A5A5A);
        chk("r20_after", nob_b, 32'h0F0F0F0F);
        rd(5'd28, 5'd4);
        chk("no_alias_a", byp_a, 32'h0);
        chk("no_alias_b", byp_b, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
